// File: rtl/fifo_bank_pkg.sv
// Shared constants for the N-channel FIFO bank: FSM state codes and a
// constant-evaluable ceiling-log2 used to size pointers and counters.
package fifo_bank_pkg;

    localparam logic [1:0] StInit   = 2'd0;
    localparam logic [1:0] StIdle   = 2'd1;
    localparam logic [1:0] StActive = 2'd2;
    localparam logic [1:0] StError  = 2'd3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_ch.sv
// Single circular FIFO channel with occupancy count and registered read data.
// Depth need not be a power of two; pointers wrap explicitly at LEN-1.
module fifo_ch
    import fifo_bank_pkg::*;
#(
    parameter int unsigned BW  = 6,
    parameter int unsigned LEN = 4
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [BW-1:0]              din,
    output logic [BW-1:0]              dout,
    output logic                       valid,
    output logic [$clog2(LEN+1)-1:0]   count,
    output logic [$clog2(LEN+1)-1:0]   count_next
);
    localparam int unsigned PW = clog2(LEN);
    localparam int unsigned CW = clog2(LEN + 1);

    logic [BW-1:0] mem [LEN];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(LEN - 1)) ? '0 : p + PW'(1);
    endfunction

    // A full channel still accepts a write when a pop frees a slot in the same cycle.
    assign pop   = rd && (count_q != '0);
    assign push  = wr && ((count_q != CW'(LEN)) || pop);
    assign count = count_q;

    always_comb begin
        count_next = count_q;
        if (push && !pop) begin
            count_next = count_q + CW'(1);
        end else if (pop && !push) begin
            count_next = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout    <= '0;
            valid   <= 1'b0;
        end else begin
            count_q <= count_next;
            valid   <= pop;
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
                dout   <= mem[rptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= din;
    end

endmodule

// File: rtl/fifo_bank_nch.sv
// N-channel FIFO bank: write demux, per-channel FIFOs, threshold flags,
// sticky overflow/underflow errors and a traffic-gating control FSM.
module fifo_bank_nch
    import fifo_bank_pkg::*;
#(
    parameter int unsigned BW  = 6,
    parameter int unsigned LEN = 4,
    parameter int unsigned NCH = 2
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       init,
    input  logic [$clog2(LEN+1)-1:0]   umbral_bajo,
    input  logic [$clog2(LEN+1)-1:0]   umbral_alto,
    input  logic                       wr,
    input  logic [$clog2(NCH)-1:0]     wr_dest,
    input  logic [BW-1:0]              data_in,
    input  logic [NCH-1:0]             rd,
    output logic [NCH*BW-1:0]          data_out,
    output logic [NCH-1:0]             rd_valid,
    output logic [NCH-1:0]             full,
    output logic [NCH-1:0]             empty,
    output logic [NCH-1:0]             almost_full,
    output logic [NCH-1:0]             almost_empty,
    output logic [NCH-1:0]             error_output,
    output logic [1:0]                 state
);
    localparam int unsigned DW = clog2(NCH);
    localparam int unsigned CW = clog2(LEN + 1);

    logic           en;
    logic [CW-1:0]  bajo_q, alto_q;
    logic [NCH-1:0] push_req, rd_req, err_set, err_q;
    logic [CW-1:0]  cnt      [NCH];
    logic [CW-1:0]  cnt_next [NCH];
    logic           dest_ok, all_empty_next;
    logic [1:0]     state_q, state_d;

    assign en           = (state_q != StInit);
    assign state        = state_q;
    assign error_output = err_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        fifo_ch #(
            .BW  (BW),
            .LEN (LEN)
        ) u_ch (
            .clk        (clk),
            .reset_L    (reset_L),
            .wr         (push_req[i]),
            .rd         (rd_req[i]),
            .din        (data_in),
            .dout       (data_out[i*BW +: BW]),
            .valid      (rd_valid[i]),
            .count      (cnt[i]),
            .count_next (cnt_next[i])
        );
    end

    always_comb begin
        dest_ok        = 1'b0;
        all_empty_next = 1'b1;
        push_req       = '0;
        rd_req         = '0;
        for (int i = 0; i < NCH; i++) begin
            if (wr_dest == DW'(i)) dest_ok = 1'b1;
            push_req[i]     = en && wr && (wr_dest == DW'(i));
            rd_req[i]       = en && rd[i];
            full[i]         = (cnt[i] == CW'(LEN));
            empty[i]        = (cnt[i] == '0);
            almost_full[i]  = (cnt[i] >= alto_q);
            almost_empty[i] = (cnt[i] <= bajo_q);
            if (cnt_next[i] != '0) all_empty_next = 1'b0;
        end
    end

    // Overflow is forgiven when a same-cycle read frees the slot.
    always_comb begin
        err_set = '0;
        for (int i = 0; i < NCH; i++) begin
            err_set[i] = (push_req[i] && full[i] && !rd[i]) || (rd_req[i] && empty[i]);
        end
        if (en && wr && !dest_ok) err_set[0] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = all_empty_next ? StIdle : StActive;
        end else begin
            unique case (state_q)
                StInit:  state_d = StInit;
                StIdle,
                StActive: begin
                    if (|err_q)              state_d = StError;
                    else if (all_empty_next) state_d = StIdle;
                    else                     state_d = StActive;
                end
                StError: state_d = StError;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= StInit;
            bajo_q  <= '0;
            alto_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            if (init) begin
                bajo_q <= umbral_bajo;
                alto_q <= umbral_alto;
                err_q  <= '0;
            end else begin
                err_q <= err_q | err_set;
            end
        end
    end

endmodule

// File: tb/tb_fifo_bank_nch.sv
// Directed plus randomized bench for fifo_bank_nch against a queue-based model.
module tb_fifo_bank_nch;
    localparam int BW  = 6;
    localparam int LEN = 4;
    localparam int NCH = 2;
    localparam int CW  = 3;

    logic              clk = 1'b0;
    logic              reset_L = 1'b0;
    logic              init = 1'b0;
    logic [CW-1:0]     umbral_bajo = '0;
    logic [CW-1:0]     umbral_alto = '0;
    logic              wr = 1'b0;
    logic [0:0]        wr_dest = '0;
    logic [BW-1:0]     data_in = '0;
    logic [NCH-1:0]    rd = '0;
    logic [NCH*BW-1:0] data_out;
    logic [NCH-1:0]    rd_valid, full, empty, almost_full, almost_empty, error_output;
    logic [1:0]        state;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0]  mq [NCH][$];
    logic [BW-1:0]  mdout [NCH];
    logic [NCH-1:0] mrv, merr;
    int             mstate, mbajo, malto;
    logic [BW-1:0]  words [5];

    fifo_bank_nch #(
        .BW  (BW),
        .LEN (LEN),
        .NCH (NCH)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .init         (init),
        .umbral_bajo  (umbral_bajo),
        .umbral_alto  (umbral_alto),
        .wr           (wr),
        .wr_dest      (wr_dest),
        .data_in      (data_in),
        .rd           (rd),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error_output (error_output),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            mq[i].delete();
            mdout[i] = '0;
        end
        mrv = '0;
        merr = '0;
        mstate = 0;
        mbajo = 0;
        malto = 0;
    endtask

    // Applies one clock of the behavioural rules to the model, using current inputs.
    task automatic model_step();
        int pre [NCH];
        logic [NCH-1:0] nerr;
        int d;
        bit any;
        nerr = '0;
        mrv = '0;
        for (int i = 0; i < NCH; i++) pre[i] = mq[i].size();
        if (mstate != 0) begin
            for (int i = 0; i < NCH; i++) begin
                if (rd[i]) begin
                    if (pre[i] > 0) begin
                        mdout[i] = mq[i].pop_front();
                        mrv[i] = 1'b1;
                    end else begin
                        nerr[i] = 1'b1;
                    end
                end
            end
            if (wr) begin
                d = int'(wr_dest);
                if (pre[d] < LEN || rd[d]) mq[d].push_back(data_in);
                else nerr[d] = 1'b1;
            end
        end
        any = 0;
        for (int i = 0; i < NCH; i++) if (mq[i].size() > 0) any = 1;
        if (init) begin
            mbajo = int'(umbral_bajo);
            malto = int'(umbral_alto);
            merr = '0;
            mstate = any ? 2 : 1;
        end else begin
            if (mstate == 1 || mstate == 2) mstate = (merr != 0) ? 3 : (any ? 2 : 1);
            merr = merr | nerr;
        end
    endtask

    task automatic check_all(input string tag);
        logic [NCH-1:0] e_full, e_empty, e_af, e_ae;
        logic [NCH*BW-1:0] e_dout;
        for (int i = 0; i < NCH; i++) begin
            e_full[i]  = (mq[i].size() == LEN);
            e_empty[i] = (mq[i].size() == 0);
            e_af[i]    = (mq[i].size() >= malto);
            e_ae[i]    = (mq[i].size() <= mbajo);
            e_dout[i*BW +: BW] = mdout[i];
        end
        chk({tag, ".empty"}, 32'(empty), 32'(e_empty));
        chk({tag, ".full"}, 32'(full), 32'(e_full));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(e_af));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(e_ae));
        chk({tag, ".error_output"}, 32'(error_output), 32'(merr));
        chk({tag, ".state"}, 32'(state), 32'(mstate));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(mrv));
        chk({tag, ".data_out"}, 32'(data_out), 32'(e_dout));
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic w, input logic [0:0] dst, input logic [BW-1:0] d,
                         input logic [NCH-1:0] r);
        wr = w;
        wr_dest = dst;
        data_in = d;
        rd = r;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".empty"}, 32'(empty), 3);
        chk({tag, ".full"}, 32'(full), 0);
        chk({tag, ".error_output"}, 32'(error_output), 0);
        chk({tag, ".state"}, 32'(state), 0);
        chk({tag, ".almost_empty"}, 32'(almost_empty), 3);
        chk({tag, ".almost_full"}, 32'(almost_full), 3);
        chk({tag, ".data_out"}, 32'(data_out), 0);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 0);
    endtask

    initial begin
        // 1: reset values, traffic ignored in INIT
        model_reset();
        #3;
        check_reset_values("rst");
        #9 reset_L = 1'b1;
        drive(1'b1, 1'b0, 6'h05, 2'b11);
        cycle("init_ign");
        chk("init_ign.empty", 32'(empty), 3);
        chk("init_ign.err", 32'(error_output), 0);

        // 2: thresholds and almost flags on ch0
        drive(1'b0, 1'b0, 6'h00, 2'b00);
        init = 1'b1;
        umbral_bajo = 3'd1;
        umbral_alto = 3'd3;
        cycle("latch");
        init = 1'b0;
        chk("latch.state", 32'(state), 1);
        drive(1'b1, 1'b0, 6'h11, 2'b00);
        cycle("w11");
        drive(1'b1, 1'b0, 6'h22, 2'b00);
        cycle("w22");
        chk("w22.ae0", 32'(almost_empty[0]), 0);
        drive(1'b1, 1'b0, 6'h33, 2'b00);
        cycle("w33");
        chk("w33.af0", 32'(almost_full[0]), 1);
        chk("w33.state", 32'(state), 2);

        // 3: overflow ch1, then drain in order
        for (int k = 0; k < 5; k++) begin
            words[k] = BW'($urandom);
            drive(1'b1, 1'b1, words[k], 2'b00);
            cycle("fill1");
        end
        chk("ovf.full1", 32'(full[1]), 1);
        chk("ovf.err1", 32'(error_output[1]), 1);
        drive(1'b0, 1'b0, 6'h00, 2'b00);
        cycle("ovf_next");
        chk("ovf_next.state", 32'(state), 3);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 6'h00, 2'b10);
            cycle("drain1");
            chk("drain1.data", 32'(data_out[BW +: BW]), 32'(words[k]));
            chk("drain1.valid", 32'(rd_valid[1]), 1);
        end

        // 4: full ch0 with simultaneous write and read
        drive(1'b1, 1'b0, 6'h44, 2'b00);
        cycle("w44");
        chk("w44.full0", 32'(full[0]), 1);
        drive(1'b1, 1'b0, 6'h55, 2'b01);
        cycle("wr_rd_full");
        chk("wr_rd_full.full0", 32'(full[0]), 1);
        chk("wr_rd_full.err0", 32'(error_output[0]), 0);
        chk("wr_rd_full.data0", 32'(data_out[0 +: BW]), 32'h11);

        // clear errors with a fresh init
        drive(1'b0, 1'b0, 6'h00, 2'b00);
        init = 1'b1;
        cycle("reinit");
        init = 1'b0;
        chk("reinit.err", 32'(error_output), 0);
        chk("reinit.state", 32'(state), 2);

        // 5: underflow on ch1 with a same-cycle write (no bypass)
        drive(1'b1, 1'b1, 6'h3F, 2'b10);
        cycle("under1");
        chk("under1.err1", 32'(error_output[1]), 1);
        chk("under1.rv1", 32'(rd_valid[1]), 0);
        drive(1'b0, 1'b0, 6'h00, 2'b10);
        cycle("rd3f");
        chk("rd3f.data1", 32'(data_out[BW +: BW]), 32'h3F);
        chk("rd3f.rv1", 32'(rd_valid[1]), 1);

        // 6: push ten words through full ch0 to wrap pointers
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, BW'($urandom), 2'b01);
            cycle("wrap0");
        end

        // randomized traffic with occasional re-init and random thresholds
        for (int k = 0; k < 80; k++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), BW'($urandom),
                  NCH'($urandom_range(0, 3)));
            init = ($urandom_range(0, 15) == 0);
            umbral_bajo = CW'($urandom_range(0, 7));
            umbral_alto = CW'($urandom_range(0, 7));
            cycle("rand");
        end

        // asynchronous reset mid-stream
        drive(1'b1, 1'b0, 6'h2A, 2'b01);
        init = 1'b0;
        @(posedge clk);
        #3;
        reset_L = 1'b0;
        #1;
        check_reset_values("rst_mid");
        model_reset();
        check_all("rst_mid_model");
        #3 reset_L = 1'b1;
        drive(1'b1, 1'b0, 6'h2A, 2'b00);
        cycle("post_rst");
        chk("post_rst.empty", 32'(empty), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
